glb_proc_bridge: RTL and testbench

- Processor-side initiator of the global buffer processor packet chain; sits west of tile 0.
- Converts processor read/write requests (request/acknowledge handshake) into packet_t write and read-request packets.
- Drives tile 0's proc_packet_w2e_wsti and collects read responses from tile 0's proc_packet_e2w_wsto.
- Tracks one outstanding read with a timeout, and flags responses that arrive late or unsolicited.

---
 rtl/global_buffer_param.sv | 13 +
 rtl/global_buffer_pkg.sv | 35 +++
 rtl/glb_proc_bridge_rd_tracker.sv | 122 ++++++++++++
 rtl/glb_proc_bridge.sv | 110 +++++++++++
 tb/tb_glb_proc_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/global_buffer_param.sv
// Global buffer shared constants: address, data and strobe widths
// of the processor packet chain plus the read-timeout fill pattern.
package global_buffer_param;

    localparam int GLB_ADDR_WIDTH  = 22;
    localparam int BANK_DATA_WIDTH = 64;
    localparam int BANK_STRB_WIDTH = BANK_DATA_WIDTH / 8;

    // Data returned to the processor when a read is abandoned on timeout.
    localparam logic [BANK_DATA_WIDTH-1:0] RD_TIMEOUT_DATA =
        64'hDEAD_BEEF_DEAD_BEEF;

endpackage

// File: rtl/global_buffer_pkg.sv
// Global buffer processor packet types (write, read request, read
// response) and the bridge read-tracker state encoding.
package global_buffer_pkg;

    import global_buffer_param::*;

    typedef struct packed {
        logic                       wr_en;
        logic [BANK_STRB_WIDTH-1:0] wr_strb;
        logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
        logic [BANK_DATA_WIDTH-1:0] wr_data;
    } wr_packet_t;

    typedef struct packed {
        logic                      rd_en;
        logic [GLB_ADDR_WIDTH-1:0] rd_addr;
    } rdrq_packet_t;

    typedef struct packed {
        logic                       rd_data_valid;
        logic [BANK_DATA_WIDTH-1:0] rd_data;
    } rdrs_packet_t;

    typedef struct packed {
        wr_packet_t   wr;
        rdrq_packet_t rdrq;
        rdrs_packet_t rdrs;
    } packet_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

endpackage

// File: rtl/glb_proc_bridge_rd_tracker.sv
// Outstanding-read tracker: RD_WAIT state, saturating wait counter,
// timeout compare, response capture and sticky late-response flag.
//   clk, reset         : clock, synchronous active-high reset
//   i_rd_accept        : read request accepted this cycle
//   i_rsp_valid/_data  : read response from the packet chain
//   i_cfg_rd_timeout   : wait limit in cycles, 0 disables
//   o_busy             : a read is outstanding (writes must stall)
//   o_rd_data/_valid   : registered response to the processor
//   o_rd_err           : response was produced by timeout
//   o_late_rsp         : sticky, response seen with no read pending
module glb_proc_bridge_rd_tracker
    import global_buffer_param::*;
    import global_buffer_pkg::*;
#(
    parameter int DATA_WIDTH    = BANK_DATA_WIDTH,
    parameter int TIMEOUT_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_rd_accept,
    input  logic                     i_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    i_rsp_data,
    input  logic [TIMEOUT_WIDTH-1:0] i_cfg_rd_timeout,
    output logic                     o_busy,
    output logic [DATA_WIDTH-1:0]    o_rd_data,
    output logic                     o_rd_data_valid,
    output logic                     o_rd_err,
    output logic                     o_late_rsp
);

    rd_state_e                r_state;
    rd_state_e                w_state_nxt;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic                     w_timeout;
    logic                     w_done;
    logic                     w_err;
    logic [DATA_WIDTH-1:0]    w_data;
    logic                     w_late;
    logic [DATA_WIDTH-1:0]    r_rd_data;
    logic                     r_rd_data_valid;
    logic                     r_rd_err;
    logic                     r_late_rsp;

    // ">=" rather than "==": if the limit is lowered below a count that
    // has already passed it, the saturating counter would never match.
    assign w_timeout = (i_cfg_rd_timeout != '0) &&
                       (r_cnt >= (i_cfg_rd_timeout - TIMEOUT_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_data      = i_rsp_data;
        w_late      = 1'b0;
        unique case (r_state)
            RD_IDLE: begin
                w_late = i_rsp_valid;
                if (i_rd_accept) begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // A real response beats a timeout in the same cycle.
                if (i_rsp_valid) begin
                    w_state_nxt = RD_IDLE;
                    w_done      = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = RD_IDLE;
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_data      = DATA_WIDTH'(RD_TIMEOUT_DATA);
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    // Counter is zero throughout IDLE so it starts at 0 on the first
    // RD_WAIT cycle, then climbs and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == RD_IDLE) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
            r_rd_err        <= 1'b0;
            r_late_rsp      <= 1'b0;
        end else begin
            r_rd_data_valid <= w_done;
            r_rd_err        <= w_err;
            r_late_rsp      <= r_late_rsp | w_late;
            if (w_done) begin
                r_rd_data <= w_data;
            end
        end
    end

    assign o_busy          = (r_state == RD_WAIT);
    assign o_rd_data       = r_rd_data;
    assign o_rd_data_valid = r_rd_data_valid;
    assign o_rd_err        = r_rd_err;
    assign o_late_rsp      = r_late_rsp;

endmodule

// File: rtl/glb_proc_bridge.sv
// Processor-side initiator of the global buffer packet chain, west of
// tile 0: turns processor write/read requests into wr/rdrq packets.
//   clk, reset            : clock, synchronous active-high reset
//   proc_wr_*/proc_rd_*   : processor requests, held until acked
//   proc_wr_ack/rd_ack    : one-cycle accept pulses
//   proc_rd_data/_valid   : read response, proc_rd_err on timeout
//   cfg_rd_timeout        : read wait limit, 0 disables
//   packet_w2e_esto       : packet to tile 0 (wr, rdrq; rdrs = 0)
//   packet_e2w_esti       : packet from tile 0 (rdrs only)
//   late_rsp_flag         : sticky unsolicited-response indicator
module glb_proc_bridge
    import global_buffer_param::*;
    import global_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH    = GLB_ADDR_WIDTH,
    parameter int DATA_WIDTH    = BANK_DATA_WIDTH,
    parameter int STRB_WIDTH    = BANK_STRB_WIDTH,
    parameter int TIMEOUT_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     proc_wr_en,
    input  logic [STRB_WIDTH-1:0]    proc_wr_strb,
    input  logic [ADDR_WIDTH-1:0]    proc_wr_addr,
    input  logic [DATA_WIDTH-1:0]    proc_wr_data,
    input  logic                     proc_rd_en,
    input  logic [ADDR_WIDTH-1:0]    proc_rd_addr,
    output logic                     proc_wr_ack,
    output logic                     proc_rd_ack,
    output logic [DATA_WIDTH-1:0]    proc_rd_data,
    output logic                     proc_rd_data_valid,
    output logic                     proc_rd_err,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_rd_timeout,
    output packet_t                  packet_w2e_esto,
    input  packet_t                  packet_e2w_esti,
    output logic                     late_rsp_flag
);

    logic         w_busy;
    logic         w_wr_acc;
    logic         w_rd_acc;
    wr_packet_t   w_wr_nxt;
    rdrq_packet_t w_rdrq_nxt;
    wr_packet_t   r_wr;
    rdrq_packet_t r_rdrq;
    logic         w_unused_e2w;

    // Write wins a tie; while a read is outstanding nothing is
    // accepted, which keeps a later write behind the pending read.
    assign w_wr_acc = !reset && !w_busy && proc_wr_en;
    assign w_rd_acc = !reset && !w_busy && proc_rd_en && !proc_wr_en;

    assign proc_wr_ack = w_wr_acc;
    assign proc_rd_ack = w_rd_acc;

    always_comb begin
        w_wr_nxt   = '0;
        w_rdrq_nxt = '0;
        unique case (1'b1)
            w_wr_acc: begin
                w_wr_nxt.wr_en   = 1'b1;
                w_wr_nxt.wr_strb = proc_wr_strb;
                w_wr_nxt.wr_addr = proc_wr_addr;
                w_wr_nxt.wr_data = proc_wr_data;
            end
            w_rd_acc: begin
                w_rdrq_nxt.rd_en   = 1'b1;
                w_rdrq_nxt.rd_addr = proc_rd_addr;
            end
            default: begin
            end
        endcase
    end

    // Packets are single-cycle: fields are zero unless a request was
    // accepted in the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr   <= '0;
            r_rdrq <= '0;
        end else begin
            r_wr   <= w_wr_nxt;
            r_rdrq <= w_rdrq_nxt;
        end
    end

    assign packet_w2e_esto = {r_wr, r_rdrq, rdrs_packet_t'('0)};

    // Write and read-request lanes of the returning packet belong to
    // other initiators and are ignored here.
    assign w_unused_e2w = ^{packet_e2w_esti.wr, packet_e2w_esti.rdrq};

    glb_proc_bridge_rd_tracker #(
        .DATA_WIDTH    (DATA_WIDTH),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_rd_tracker (
        .clk              (clk),
        .reset            (reset),
        .i_rd_accept      (w_rd_acc),
        .i_rsp_valid      (packet_e2w_esti.rdrs.rd_data_valid),
        .i_rsp_data       (packet_e2w_esti.rdrs.rd_data),
        .i_cfg_rd_timeout (cfg_rd_timeout),
        .o_busy           (w_busy),
        .o_rd_data        (proc_rd_data),
        .o_rd_data_valid  (proc_rd_data_valid),
        .o_rd_err         (proc_rd_err),
        .o_late_rsp       (late_rsp_flag)
    );

endmodule

// File: tb/tb_glb_proc_bridge.sv
// Testbench for glb_proc_bridge: directed and randomized scenarios
// checked against a cycle-timeline model of the read/write protocol.
module tb_glb_proc_bridge;

    import global_buffer_param::*;
    import global_buffer_pkg::*;

    localparam logic [63:0] TMO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        proc_wr_en;
    logic [7:0]  proc_wr_strb;
    logic [21:0] proc_wr_addr;
    logic [63:0] proc_wr_data;
    logic        proc_rd_en;
    logic [21:0] proc_rd_addr;
    logic        proc_wr_ack;
    logic        proc_rd_ack;
    logic [63:0] proc_rd_data;
    logic        proc_rd_data_valid;
    logic        proc_rd_err;
    logic [11:0] cfg_rd_timeout;
    packet_t     pkt_w2e;
    packet_t     pkt_e2w;
    logic        late_rsp_flag;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_late = 1'b0;

    glb_proc_bridge dut (
        .clk                (clk),
        .reset              (reset),
        .proc_wr_en         (proc_wr_en),
        .proc_wr_strb       (proc_wr_strb),
        .proc_wr_addr       (proc_wr_addr),
        .proc_wr_data       (proc_wr_data),
        .proc_rd_en         (proc_rd_en),
        .proc_rd_addr       (proc_rd_addr),
        .proc_wr_ack        (proc_wr_ack),
        .proc_rd_ack        (proc_rd_ack),
        .proc_rd_data       (proc_rd_data),
        .proc_rd_data_valid (proc_rd_data_valid),
        .proc_rd_err        (proc_rd_err),
        .cfg_rd_timeout     (cfg_rd_timeout),
        .packet_w2e_esto    (pkt_w2e),
        .packet_e2w_esti    (pkt_e2w),
        .late_rsp_flag      (late_rsp_flag)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are read at
    // the falling edge of the same cycle.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        proc_wr_en = 1'b1;
        proc_rd_en = 1'b1;
        pkt_e2w.rdrs.rd_data_valid = 1'b1;
        nxt();
        nxt();
        smp();
        n_cmp++; if (proc_wr_ack !== 1'b0) begin n_err++; $display("FAIL rst_wr_ack: got %b want 0", proc_wr_ack); end
        n_cmp++; if (proc_rd_ack !== 1'b0) begin n_err++; $display("FAIL rst_rd_ack: got %b want 0", proc_rd_ack); end
        n_cmp++; if (proc_rd_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_dv: got %b want 0", proc_rd_data_valid); end
        n_cmp++; if (proc_rd_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", proc_rd_err); end
        n_cmp++; if (proc_rd_data !== 64'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", proc_rd_data); end
        n_cmp++; if (pkt_w2e !== '0) begin n_err++; $display("FAIL rst_pkt: got %h want 0", pkt_w2e); end
        nxt();
        reset = 1'b0;
        proc_wr_en = 1'b0;
        proc_rd_en = 1'b0;
        pkt_e2w.rdrs.rd_data_valid = 1'b0;
        smp();
        n_cmp++; if (late_rsp_flag !== 1'b0) begin n_err++; $display("FAIL rst_late: got %b want 0", late_rsp_flag); end
    endtask

    task automatic test_single_write();
        wr_packet_t exp_wr;
        exp_wr = '{wr_en: 1'b1, wr_strb: 8'hFF, wr_addr: 22'h100, wr_data: 64'h1122334455667788};
        nxt();
        proc_wr_en = 1'b1;
        proc_wr_strb = 8'hFF;
        proc_wr_addr = 22'h100;
        proc_wr_data = 64'h1122334455667788;
        smp();
        n_cmp++; if (proc_wr_ack !== 1'b1) begin n_err++; $display("FAIL sw_ack: got %b want 1", proc_wr_ack); end
        n_cmp++; if (proc_rd_ack !== 1'b0) begin n_err++; $display("FAIL sw_rd_ack: got %b want 0", proc_rd_ack); end
        nxt();
        proc_wr_en = 1'b0;
        smp();
        n_cmp++; if (pkt_w2e.wr !== exp_wr) begin n_err++; $display("FAIL sw_pkt: got %h want %h", pkt_w2e.wr, exp_wr); end
        n_cmp++; if (pkt_w2e.rdrq.rd_en !== 1'b0) begin n_err++; $display("FAIL sw_rdrq: got %b want 0", pkt_w2e.rdrq.rd_en); end
        nxt();
        smp();
        n_cmp++; if (pkt_w2e.wr.wr_en !== 1'b0) begin n_err++; $display("FAIL sw_once: got %b want 0", pkt_w2e.wr.wr_en); end
    endtask

    task automatic test_back_to_back();
        wr_packet_t q[$];
        wr_packet_t e;
        for (int i = 0; i < 5; i++) begin
            nxt();
            if (i < 4) begin
                proc_wr_en = 1'b1;
                proc_wr_strb = 8'($urandom);
                proc_wr_addr = 22'($urandom);
                proc_wr_data = {$urandom, $urandom};
                q.push_back('{1'b1, proc_wr_strb, proc_wr_addr, proc_wr_data});
            end else begin
                proc_wr_en = 1'b0;
            end
            smp();
            if (i < 4) begin
                n_cmp++; if (proc_wr_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack%0d: got %b want 1", i, proc_wr_ack); end
            end
            if (i > 0) begin
                e = q.pop_front();
                n_cmp++; if (pkt_w2e.wr !== e) begin n_err++; $display("FAIL b2b_pkt%0d: got %h want %h", i, pkt_w2e.wr, e); end
            end
        end
        nxt();
        smp();
        n_cmp++; if (pkt_w2e.wr.wr_en !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", pkt_w2e.wr.wr_en); end
    endtask

    // Model: k counts cycles from the rdrq cycle (k=0). The timeout
    // fires at k=cfg-1 unless a response came at or before that; the
    // result appears one cycle after whichever event wins.
    task automatic run_read(input logic [21:0] addr, input int lat,
                            input int cfg, input logic [63:0] rdata,
                            input bit hold_wr, input string tag);
        bit          tmo_wins;
        int          d;
        int          last;
        logic [21:0] waddr;
        rdrq_packet_t exp_rq;
        tmo_wins = (cfg != 0) && (lat < 0 || lat >= cfg);
        d = tmo_wins ? cfg : lat + 1;
        last = (lat > d) ? lat + 1 : d + 1;
        waddr = 22'($urandom);
        exp_rq = '{rd_en: 1'b1, rd_addr: addr};
        nxt();
        proc_rd_en = 1'b1;
        proc_rd_addr = addr;
        cfg_rd_timeout = 12'(cfg);
        smp();
        n_cmp++; if (proc_rd_ack !== 1'b1) begin n_err++; $display("FAIL %s_rd_ack: got %b want 1", tag, proc_rd_ack); end
        for (int k = 0; k <= last; k++) begin
            nxt();
            if (k == 0) begin
                proc_rd_en = 1'b0;
                proc_wr_en = hold_wr;
                proc_wr_addr = waddr;
            end
            if (hold_wr && k == d + 1) proc_wr_en = 1'b0;
            pkt_e2w.rdrs.rd_data_valid = (k == lat);
            pkt_e2w.rdrs.rd_data = rdata;
            smp();
            if (k == 0) begin
                n_cmp++; if (pkt_w2e.rdrq !== exp_rq) begin n_err++; $display("FAIL %s_rdrq: got %h want %h", tag, pkt_w2e.rdrq, exp_rq); end
            end
            n_cmp++; if (proc_rd_data_valid !== (k == d)) begin n_err++; $display("FAIL %s_dv_k%0d: got %b want %b", tag, k, proc_rd_data_valid, k == d); end
            if (k == d) begin
                n_cmp++; if (proc_rd_data !== (tmo_wins ? TMO_DATA : rdata)) begin n_err++; $display("FAIL %s_data: got %h want %h", tag, proc_rd_data, tmo_wins ? TMO_DATA : rdata); end
                n_cmp++; if (proc_rd_err !== tmo_wins) begin n_err++; $display("FAIL %s_err: got %b want %b", tag, proc_rd_err, tmo_wins); end
            end
            if (hold_wr && k <= d) begin
                n_cmp++; if (proc_wr_ack !== (k == d)) begin n_err++; $display("FAIL %s_wr_ack_k%0d: got %b want %b", tag, k, proc_wr_ack, k == d); end
            end
            if (hold_wr && k == d + 1) begin
                n_cmp++; if (pkt_w2e.wr.wr_en !== 1'b1 || pkt_w2e.wr.wr_addr !== waddr) begin n_err++; $display("FAIL %s_wr_pkt: got %b/%h want 1/%h", tag, pkt_w2e.wr.wr_en, pkt_w2e.wr.wr_addr, waddr); end
            end
        end
        pkt_e2w.rdrs.rd_data_valid = 1'b0;
        if (tmo_wins && lat >= 0) exp_late = 1'b1;
        n_cmp++; if (late_rsp_flag !== exp_late) begin n_err++; $display("FAIL %s_late: got %b want %b", tag, late_rsp_flag, exp_late); end
    endtask

    task automatic test_read_response();
        run_read(22'h200, 6, 0, 64'hCAFE, 1'b1, "rd_cafe");
    endtask

    task automatic test_simultaneous();
        logic [63:0] rdat;
        rdat = {$urandom, $urandom};
        nxt();
        proc_wr_en = 1'b1;
        proc_wr_addr = 22'h3A5;
        proc_rd_en = 1'b1;
        proc_rd_addr = 22'h1C3;
        cfg_rd_timeout = 12'd0;
        smp();
        n_cmp++; if (proc_wr_ack !== 1'b1 || proc_rd_ack !== 1'b0) begin n_err++; $display("FAIL sim_c0: got wr%b rd%b want wr1 rd0", proc_wr_ack, proc_rd_ack); end
        nxt();
        proc_wr_en = 1'b0;
        smp();
        n_cmp++; if (proc_rd_ack !== 1'b1) begin n_err++; $display("FAIL sim_rd_ack: got %b want 1", proc_rd_ack); end
        n_cmp++; if (pkt_w2e.wr.wr_en !== 1'b1 || pkt_w2e.rdrq.rd_en !== 1'b0) begin n_err++; $display("FAIL sim_pkt1: got wr%b rq%b want wr1 rq0", pkt_w2e.wr.wr_en, pkt_w2e.rdrq.rd_en); end
        nxt();
        proc_rd_en = 1'b0;
        pkt_e2w.rdrs.rd_data_valid = 1'b1;
        pkt_e2w.rdrs.rd_data = rdat;
        smp();
        n_cmp++; if (pkt_w2e.wr.wr_en !== 1'b0 || pkt_w2e.rdrq.rd_en !== 1'b1 || pkt_w2e.rdrq.rd_addr !== 22'h1C3) begin n_err++; $display("FAIL sim_pkt2: got wr%b rq%b %h want wr0 rq1 1c3", pkt_w2e.wr.wr_en, pkt_w2e.rdrq.rd_en, pkt_w2e.rdrq.rd_addr); end
        nxt();
        pkt_e2w.rdrs.rd_data_valid = 1'b0;
        smp();
        n_cmp++; if (proc_rd_data_valid !== 1'b1 || proc_rd_data !== rdat) begin n_err++; $display("FAIL sim_rsp: got %b %h want 1 %h", proc_rd_data_valid, proc_rd_data, rdat); end
    endtask

    task automatic test_race();
        run_read(22'h044, 3, 4, 64'h0123_4567_89AB_CDEF, 1'b0, "race_rsp");
        run_read(22'h048, 4, 4, 64'h1111_2222_3333_4444, 1'b0, "race_tmo");
    endtask

    task automatic test_no_timeout();
        run_read(22'h2F0, 200, 0, 64'hFEED_FACE_0BAD_F00D, 1'b0, "no_tmo");
    endtask

    task automatic test_timeout_late();
        run_read(22'h155, 15, 10, 64'h5555_AAAA_5555_AAAA, 1'b0, "tmo_late");
    endtask

    task automatic test_random();
        int cfg;
        int lat;
        for (int i = 0; i < 10; i++) begin
            cfg = $urandom_range(0, 12);
            lat = $urandom_range(0, 16);
            run_read(22'($urandom), lat, cfg, {$urandom, $urandom}, 1'($urandom), "rnd");
        end
    endtask

    // Hold a read far past counter saturation with no timeout, then set
    // the maximum limit: the saturated count already meets it.
    task automatic test_cfg_lower();
        int seen;
        seen = 0;
        nxt();
        proc_rd_en = 1'b1;
        proc_rd_addr = 22'h0AA;
        cfg_rd_timeout = 12'd0;
        smp();
        n_cmp++; if (proc_rd_ack !== 1'b1) begin n_err++; $display("FAIL sat_ack: got %b want 1", proc_rd_ack); end
        nxt();
        proc_rd_en = 1'b0;
        for (int k = 1; k < 4200; k++) begin
            nxt();
            smp();
            if (proc_rd_data_valid !== 1'b0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL sat_quiet: got %0d responses want 0", seen); end
        nxt();
        cfg_rd_timeout = 12'hFFF;
        smp();
        n_cmp++; if (proc_rd_data_valid !== 1'b0) begin n_err++; $display("FAIL sat_early: got %b want 0", proc_rd_data_valid); end
        nxt();
        cfg_rd_timeout = 12'd0;
        smp();
        n_cmp++; if (proc_rd_data_valid !== 1'b1 || proc_rd_err !== 1'b1 || proc_rd_data !== TMO_DATA) begin n_err++; $display("FAIL sat_tmo: got %b %b %h want 1 1 %h", proc_rd_data_valid, proc_rd_err, proc_rd_data, TMO_DATA); end
    endtask

    task automatic test_reset_mid_read();
        nxt();
        proc_rd_en = 1'b1;
        proc_rd_addr = 22'h321;
        cfg_rd_timeout = 12'd0;
        nxt();
        proc_rd_en = 1'b0;
        smp();
        n_cmp++; if (pkt_w2e.rdrq.rd_en !== 1'b1) begin n_err++; $display("FAIL rmr_rdrq: got %b want 1", pkt_w2e.rdrq.rd_en); end
        nxt();
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        exp_late = 1'b0;
        smp();
        n_cmp++; if (proc_rd_data_valid !== 1'b0 || proc_rd_err !== 1'b0 || proc_rd_data !== 64'h0) begin n_err++; $display("FAIL rmr_out: got %b %b %h want 0 0 0", proc_rd_data_valid, proc_rd_err, proc_rd_data); end
        n_cmp++; if (late_rsp_flag !== 1'b0 || pkt_w2e !== '0) begin n_err++; $display("FAIL rmr_flag_pkt: got %b %h want 0 0", late_rsp_flag, pkt_w2e); end
        nxt();
        nxt();
        pkt_e2w.rdrs.rd_data_valid = 1'b1;
        pkt_e2w.rdrs.rd_data = 64'h5A5A;
        nxt();
        pkt_e2w.rdrs.rd_data_valid = 1'b0;
        exp_late = 1'b1;
        smp();
        n_cmp++; if (proc_rd_data_valid !== 1'b0) begin n_err++; $display("FAIL rmr_dv: got %b want 0", proc_rd_data_valid); end
        n_cmp++; if (late_rsp_flag !== exp_late) begin n_err++; $display("FAIL rmr_late: got %b want %b", late_rsp_flag, exp_late); end
    endtask

    initial begin
        reset = 1'b1;
        proc_wr_en = 1'b0;
        proc_wr_strb = '0;
        proc_wr_addr = '0;
        proc_wr_data = '0;
        proc_rd_en = 1'b0;
        proc_rd_addr = '0;
        cfg_rd_timeout = '0;
        pkt_e2w = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_response();
        test_simultaneous();
        test_race();
        test_no_timeout();
        test_timeout_late();
        test_random();
        test_cfg_lower();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
